// File: rtl/nand_seq_pkg.sv
// Shared types and constants for the NAND operand sequencer.
// Provides the FSM state enum, default operand width and count-width helper.
package nand_seq_pkg;

  localparam int NAND_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_DONE
  } state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nand_seq_buf.sv
// Operand-pair storage: DEPTH x (2*WIDTH) registers, one write port,
// one asynchronous read port. Not reset; validity is tracked by the caller.
module nand_seq_buf
  import nand_seq_pkg::*;
#(
  parameter int WIDTH = NAND_W,
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wa_i,
  input  logic [WIDTH-1:0] wb_i,
  input  logic [IW-1:0]    raddr_i,
  output logic [WIDTH-1:0] ra_o,
  output logic [WIDTH-1:0] rb_o
);

  logic [2*WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= {wa_i, wb_i};
  end

  assign ra_o = mem_q[raddr_i][2*WIDTH-1:WIDTH];
  assign rb_o = mem_q[raddr_i][WIDTH-1:0];

endmodule

// File: rtl/nand_operand_seq.sv
// Operand sequencer: buffers (A,B) pairs, then replays them on registered
// a_out/b_out via valid/ready. Ports: load (wr_en/wr_a/wr_b, full, count),
// control (start, busy, done), stream (a_out, b_out, out_valid, out_ready).
// Define NAND_SEQ_LOOP_EN for looping playback with a `stop` input.
module nand_operand_seq
  import nand_seq_pkg::*;
#(
  parameter int WIDTH = NAND_W,
  parameter int DEPTH = 4,
  localparam int CW = cnt_w(DEPTH),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_a,
  input  logic [WIDTH-1:0] wr_b,
  output logic             full,
  output logic [CW-1:0]    count,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             out_valid,
`ifdef NAND_SEQ_LOOP_EN
  input  logic             stop,
`endif
  input  logic             out_ready
);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic             we;
  logic             hs;
  logic             last;
  logic             full_w;
  logic [IW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  assign full_w = (count_q == CW'(DEPTH));
  assign hs     = vld_q & out_ready;
  assign last   = ((CW'(idx_q) + CW'(1)) == count_q);
  // Read address is the entry to load into the output regs at this edge.
  assign rd_idx = (state_q == S_PLAY && !last) ? idx_q + IW'(1) : '0;

  nand_seq_buf #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(count_q[IW-1:0]),
    .wa_i   (wr_a),
    .wb_i   (wr_b),
    .raddr_i(rd_idx),
    .ra_o   (rd_a),
    .rb_o   (rd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    a_d     = a_q;
    b_d     = b_q;
    we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // start has priority; a same-cycle write is dropped
        if (start && count_q != '0) begin
          state_d = S_PLAY;
          idx_d   = '0;
          vld_d   = 1'b1;
          a_d     = rd_a;
          b_d     = rd_b;
        end else if (wr_en && !full_w) begin
          we      = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      S_PLAY: begin
`ifdef NAND_SEQ_LOOP_EN
        if (stop) begin
          state_d = S_DONE;
          vld_d   = 1'b0;
          a_d     = '0;
          b_d     = '0;
        end else if (hs) begin
          idx_d = rd_idx;
          a_d   = rd_a;
          b_d   = rd_b;
        end
`else
        if (hs && last) begin
          state_d = S_DONE;
          vld_d   = 1'b0;
          a_d     = '0;
          b_d     = '0;
        end else if (hs) begin
          idx_d = rd_idx;
          a_d   = rd_a;
          b_d   = rd_b;
        end
`endif
      end
      S_DONE: begin
        count_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full      = full_w;
  assign count     = count_q;
  assign busy      = (state_q == S_PLAY);
  assign done      = (state_q == S_DONE);
  assign out_valid = vld_q;
  assign a_out     = a_q;
  assign b_out     = b_q;

endmodule

// File: tb/tb_nand_operand_seq.sv
// Directed, table-driven bench for nand_operand_seq.
// Rows are applied one clock each and outputs compared 1ns after the edge.
module tb_nand_operand_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_a = '0;
  logic [3:0] wr_b = '0;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
`ifdef NAND_SEQ_LOOP_EN
  logic       stop = 1'b0;
`endif
  logic       full;
  logic [2:0] count;
  logic       busy;
  logic       done;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic       out_valid;

  int checks = 0;
  int failures = 0;

  nand_operand_seq #(
    .WIDTH(4),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_a     (wr_a),
    .wr_b     (wr_b),
    .full     (full),
    .count    (count),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .a_out    (a_out),
    .b_out    (b_out),
    .out_valid(out_valid),
`ifdef NAND_SEQ_LOOP_EN
    .stop     (stop),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [3:0] wa;
    logic [3:0] wb;
    logic       st;
    logic       rdy;
    logic       stp;
    logic       ev;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       ed;
    logic       ebsy;
    logic [2:0] ec;
    logic       ef;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic wr, logic [3:0] wa, logic [3:0] wb,
    logic st, logic rdy, logic stp,
    logic ev, logic [3:0] ea, logic [3:0] eb,
    logic ed, logic ebsy, logic [2:0] ec, logic ef);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wb = wb;
    v.st = st; v.rdy = rdy; v.stp = stp;
    v.ev = ev; v.ea = ea; v.eb = eb;
    v.ed = ed; v.ebsy = ebsy; v.ec = ec; v.ef = ef;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string tag, vec_t v);
    chk({tag, " valid"}, 8'(out_valid), 8'(v.ev));
    chk({tag, " a"}, 8'(a_out), 8'(v.ea));
    chk({tag, " b"}, 8'(b_out), 8'(v.eb));
    chk({tag, " done"}, 8'(done), 8'(v.ed));
    chk({tag, " busy"}, 8'(busy), 8'(v.ebsy));
    chk({tag, " count"}, 8'(count), 8'(v.ec));
    chk({tag, " full"}, 8'(full), 8'(v.ef));
  endtask

  task automatic apply(vec_t v, string tag);
    wr_en = v.wr;
    wr_a = v.wa;
    wr_b = v.wb;
    start = v.st;
    out_ready = v.rdy;
`ifdef NAND_SEQ_LOOP_EN
    stop = v.stp;
`endif
    @(posedge clk);
    #1;
    chk_out(tag, v);
  endtask

  task automatic load3();
    apply(mk(1, 4'h2, 4'h2, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0), "ld0");
    apply(mk(1, 4'h4, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 0), "ld1");
    apply(mk(1, 4'hC, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 3'd3, 0), "ld2");
  endtask

  initial begin
    vec_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0);

    // Basic 3-pair playback, ready always high; stp on the final accept
    // makes the loop build end the same way.
    tbl.push_back(mk(1, 4'h2, 4'h2, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0));
    tbl.push_back(mk(1, 4'h4, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 0));
    tbl.push_back(mk(1, 4'hC, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 3'd3, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 4'h2, 4'h2, 0, 1, 3'd3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'h4, 4'h8, 0, 1, 3'd3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'hC, 4'hF, 0, 1, 3'd3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 3'd3, 0));
    tbl.push_back(z);
    // Stall pattern 1,0,0,1,1; a write and a start during PLAY are ignored
    tbl.push_back(mk(1, 4'h2, 4'h2, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0));
    tbl.push_back(mk(1, 4'h4, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 0));
    tbl.push_back(mk(1, 4'hC, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 3'd3, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 4'h2, 4'h2, 0, 1, 3'd3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'h4, 4'h8, 0, 1, 3'd3, 0));
    tbl.push_back(mk(1, 4'h7, 4'h7, 1, 0, 0, 1, 4'h4, 4'h8, 0, 1, 3'd3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'h4, 4'h8, 0, 1, 3'd3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'hC, 4'hF, 0, 1, 3'd3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 3'd3, 0));
    tbl.push_back(z);
    // Fill to DEPTH, overflow write ignored, exactly 4 pairs out
    tbl.push_back(mk(1, 4'h1, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0));
    tbl.push_back(mk(1, 4'h3, 4'h5, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 0));
    tbl.push_back(mk(1, 4'hA, 4'h6, 0, 0, 0, 0, 0, 0, 0, 0, 3'd3, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 3'd4, 1));
    tbl.push_back(mk(1, 4'h7, 4'h7, 0, 0, 0, 0, 0, 0, 0, 0, 3'd4, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 4'h1, 4'hE, 0, 1, 3'd4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'h3, 4'h5, 0, 1, 3'd4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'hA, 4'h6, 0, 1, 3'd4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 4'hF, 4'hF, 0, 1, 3'd4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 3'd4, 1));
    tbl.push_back(z);
    // start with count=0 ignored; start+write: start wins, write dropped
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0));
    tbl.push_back(mk(1, 4'h9, 4'h6, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0));
    tbl.push_back(mk(1, 4'h5, 4'hA, 1, 1, 0, 1, 4'h9, 4'h6, 0, 1, 3'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 3'd1, 0));
    tbl.push_back(z);

    // Reset values, checked while rst_n is still low
    #2;
    chk_out("reset", z);
    @(posedge clk);
    #1;
    chk_out("reset_clk", z);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // Asynchronous reset while the 2nd pair is presented
    load3();
    apply(mk(0, 0, 0, 1, 1, 0, 1, 4'h2, 4'h2, 0, 1, 3'd3, 0), "r_p0");
    apply(mk(0, 0, 0, 0, 1, 0, 1, 4'h4, 4'h8, 0, 1, 3'd3, 0), "r_p1");
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", z);
    #3;
    rst_n = 1'b1;
    apply(mk(1, 4'h3, 4'h3, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0), "post_ld");
    apply(mk(0, 0, 0, 1, 1, 0, 1, 4'h3, 4'h3, 0, 1, 3'd1, 0), "post_p0");
    apply(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 3'd1, 0), "post_done");
    apply(z, "post_idle");

`ifdef NAND_SEQ_LOOP_EN
    // Looping: p0,p1,p0,p1,p0 then stop on the 5th handshake
    apply(mk(1, 4'h1, 4'h2, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0), "lp_ld0");
    apply(mk(1, 4'h4, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 0), "lp_ld1");
    apply(mk(0, 0, 0, 1, 1, 0, 1, 4'h1, 4'h2, 0, 1, 3'd2, 0), "lp_1");
    apply(mk(0, 0, 0, 0, 1, 0, 1, 4'h4, 4'h8, 0, 1, 3'd2, 0), "lp_2");
    apply(mk(0, 0, 0, 0, 1, 0, 1, 4'h1, 4'h2, 0, 1, 3'd2, 0), "lp_3");
    apply(mk(0, 0, 0, 0, 1, 0, 1, 4'h4, 4'h8, 0, 1, 3'd2, 0), "lp_4");
    apply(mk(0, 0, 0, 0, 1, 0, 1, 4'h1, 4'h2, 0, 1, 3'd2, 0), "lp_5");
    apply(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 3'd2, 0), "lp_done");
    apply(z, "lp_idle");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
